// File: rtl/lru_prof_pkg.sv
// Shared types and width helpers for the LRU stack profiler.
// Contents: FSM state encoding, clog2, derived-width helpers, counter-select codes.
// No ports (package).
package lru_prof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_UPDATE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned sets,
                                          input int unsigned block_bytes);
        return addr_w - clog2(sets) - clog2(block_bytes);
    endfunction

    // One hit bin per power-of-two associativity 1..ways.
    function automatic int unsigned nbins(input int unsigned ways);
        return clog2(ways) + 1;
    endfunction

    // Select width covers the hit bins plus the miss and access counters.
    function automatic int unsigned sel_w(input int unsigned ways);
        return clog2(nbins(ways) + 2);
    endfunction

    function automatic int unsigned csel_miss(input int unsigned n_bins);
        return n_bins;
    endfunction

    function automatic int unsigned csel_acc(input int unsigned n_bins);
        return n_bins + 1;
    endfunction

endpackage

// File: rtl/lru_prof_match.sv
// Parallel tag compare across one set with lowest-way priority.
// Ports:
//   lines   in  WAYS x {valid, tag}  set contents, way 0 = MRU
//   tag     in  TAG_W                lookup tag
//   hit_c   out 1                    some valid line matches (combinational)
//   depth_c out WAY_W+1              lowest matching way; WAYS when no match (combinational)
module lru_prof_match
    import lru_prof_pkg::*;
#(
    parameter int unsigned WAYS  = 16,
    parameter int unsigned TAG_W = 22
) (
    input  logic [WAYS-1:0][TAG_W:0] lines,
    input  logic [TAG_W-1:0]         tag,
    output logic                     hit_c,
    output logic [clog2(WAYS):0]     depth_c
);

    localparam int unsigned DEPTH_W = clog2(WAYS) + 1;

    // Scan from LRU towards MRU so the lowest matching way is the last written.
    always_comb begin
        hit_c   = 1'b0;
        depth_c = DEPTH_W'(WAYS);
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (lines[w][TAG_W] && (lines[w][TAG_W-1:0] == tag)) begin
                hit_c   = 1'b1;
                depth_c = DEPTH_W'(w);
            end
        end
    end

endmodule

// File: rtl/lru_stack_profiler.sv
// LRU-stack cache profiler: models a SETS x WAYS true-LRU cache and reports the
// stack depth of every hit, with per-associativity hit bins, miss and access counters.
// Optional build macro: LRU_PROF_SATURATE_EN (counters saturate instead of wrapping).
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   req_valid/ready request handshake (ready only in IDLE), req_addr byte address
//   resp_valid/ready response handshake, resp_hit, resp_depth (WAYS on miss)
//   stat_clr        pulse: clear all counters (tag store kept)
//   cnt_sel         counter select: bins 0..NBINS-1, NBINS=miss, NBINS+1=access
//   cnt_rdata       combinational read of the selected counter
module lru_stack_profiler
    import lru_prof_pkg::*;
#(
    parameter int unsigned WAYS        = 16,
    parameter int unsigned SETS        = 64,
    parameter int unsigned BLOCK_BYTES = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_hit,
    output logic [clog2(WAYS):0]      resp_depth,
    input  logic                      stat_clr,
    input  logic [sel_w(WAYS)-1:0]    cnt_sel,
    output logic [CNT_W-1:0]          cnt_rdata
);

    localparam int unsigned OFF_W   = clog2(BLOCK_BYTES);
    localparam int unsigned IDX_W   = clog2(SETS);
    localparam int unsigned WAY_W   = clog2(WAYS);
    localparam int unsigned TAG_W   = tag_w(ADDR_W, SETS, BLOCK_BYTES);
    localparam int unsigned NBINS   = nbins(WAYS);
    localparam int unsigned SEL_W   = sel_w(WAYS);
    localparam int unsigned LINE_W  = TAG_W + 1;
    localparam int unsigned DEPTH_W = WAY_W + 1;

    state_t state, state_next;
    logic   capture, latch, update;

    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;

    logic [WAYS-1:0][LINE_W-1:0] lines_q [SETS];
    logic [WAYS-1:0][LINE_W-1:0] cur_set;
    logic [WAYS-1:0][LINE_W-1:0] new_set;

    logic               match_hit;
    logic [DEPTH_W-1:0] match_depth;

    logic [CNT_W-1:0] bin_q [NBINS];
    logic [CNT_W-1:0] miss_q;
    logic [CNT_W-1:0] acc_q;

    // Block-offset bits do not participate in the lookup.
    logic unused_off;
    assign unused_off = ^req_addr[OFF_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (req_valid)  state_next = ST_LOOKUP;
            ST_LOOKUP:                 state_next = ST_UPDATE;
            ST_UPDATE:                 state_next = ST_RESP;
            ST_RESP:   if (resp_ready) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        capture = 1'b0;
        latch   = 1'b0;
        update  = 1'b0;
        unique case (state)
            ST_IDLE:   capture = req_valid;
            ST_LOOKUP: latch   = 1'b1;
            ST_UPDATE: update  = 1'b1;
            default:   ;
        endcase
    end

    // Handshake outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            req_ready  <= (state_next == ST_IDLE);
            resp_valid <= (state_next == ST_RESP);
        end
    end

    // Request capture and lookup result latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q      <= '0;
            idx_q      <= '0;
            resp_hit   <= 1'b0;
            resp_depth <= '0;
        end else begin
            if (capture) begin
                tag_q <= req_addr[ADDR_W-1 -: TAG_W];
                idx_q <= req_addr[OFF_W +: IDX_W];
            end
            if (latch) begin
                resp_hit   <= match_hit;
                resp_depth <= match_depth;
            end
        end
    end

    assign cur_set = lines_q[idx_q];

    lru_prof_match #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) u_match (
        .lines   (cur_set),
        .tag     (tag_q),
        .hit_c   (match_hit),
        .depth_c (match_depth)
    );

    // Move-to-front: ways 1..d take their upper neighbour; a miss uses d=WAYS,
    // shifting the whole set and dropping the LRU line.
    always_comb begin
        new_set    = cur_set;
        new_set[0] = resp_hit ? cur_set[resp_depth[WAY_W-1:0]] : {1'b1, tag_q};
        for (int w = 1; w < int'(WAYS); w++) begin
            if (w <= int'(resp_depth)) new_set[w] = cur_set[w-1];
        end
    end

    // Tag store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < int'(SETS); s++) lines_q[s] <= '0;
        end else if (update) begin
            lines_q[idx_q] <= new_set;
        end
    end

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef LRU_PROF_SATURATE_EN
        return (&c) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    // Statistics counters; a clear overrides a coincident increment.
    always_ff @(posedge clk) begin
        if (!reset || stat_clr) begin
            for (int k = 0; k < int'(NBINS); k++) bin_q[k] <= '0;
            miss_q <= '0;
            acc_q  <= '0;
        end else if (update) begin
            acc_q <= cnt_inc(acc_q);
            if (resp_hit) begin
                for (int k = 0; k < int'(NBINS); k++) begin
                    if (int'(resp_depth) < (1 << k)) bin_q[k] <= cnt_inc(bin_q[k]);
                end
            end else begin
                miss_q <= cnt_inc(miss_q);
            end
        end
    end

    // Counter read mux; unused select codes read zero.
    always_comb begin
        cnt_rdata = '0;
        for (int k = 0; k < int'(NBINS); k++) begin
            if (cnt_sel == SEL_W'(k)) cnt_rdata = bin_q[k];
        end
        if (cnt_sel == SEL_W'(csel_miss(NBINS))) cnt_rdata = miss_q;
        if (cnt_sel == SEL_W'(csel_acc(NBINS)))  cnt_rdata = acc_q;
    end

endmodule
